// File: rtl/op_issue_pkg.sv
// op_issue_pkg: shared widths, opcode names and FSM states for the opcode issue encoder
package op_issue_pkg;
    localparam int N_REQ = 16;
    localparam int OP_W  = $clog2(N_REQ);

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP  = 4'd0;
    localparam op_t OP_ADD  = 4'd1;
    localparam op_t OP_SUB  = 4'd2;
    localparam op_t OP_MUL  = 4'd3;
    localparam op_t OP_DIV  = 4'd4;
    localparam op_t OP_MOD  = 4'd5;
    localparam op_t OP_AND  = 4'd6;
    localparam op_t OP_OR   = 4'd7;
    localparam op_t OP_XOR  = 4'd8;
    localparam op_t OP_NOT  = 4'd9;
    localparam op_t OP_NAND = 4'd10;
    localparam op_t OP_NOR  = 4'd11;
    localparam op_t OP_XNOR = 4'd12;
    localparam op_t OP_SHL  = 4'd13;
    localparam op_t OP_SHR  = 4'd14;
    localparam op_t OP_RST  = 4'd15;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; rotate by ptr, isolate lowest set bit, encode, un-rotate
module rr_pick
    import op_issue_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  op_t              ptr_i,
    output logic             found_o,
    output op_t              idx_o
);
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [N_REQ-1:0]   w_low;
    op_t                w_enc;

    assign w_dbl   = {req_i, req_i};
    assign w_rot   = N_REQ'(w_dbl >> ptr_i);
    assign w_low   = w_rot & (~w_rot + N_REQ'(1));
    assign found_o = |req_i;
    assign idx_o   = w_enc + ptr_i;

    // one-hot to binary of the isolated lowest set bit in the rotated frame
    always_comb begin
        w_enc = '0;
        for (int k = 0; k < N_REQ; k++)
            if (w_low[k]) w_enc = OP_W'(k);
    end
endmodule

// File: rtl/op_issue_encoder.sv
// op_issue_encoder: collects opcode requests, arbitrates and issues one opcode per cycle over valid/ready
// OP_ISSUE_RR_EN defined: round-robin from a rotating pointer; undefined: lowest index wins.
module op_issue_encoder
    import op_issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output op_t              op_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic [N_REQ-1:0] pend_o,
    output logic             busy_o,
    output logic             ovr_o,
    input  logic             ovr_clr_i
);
    state_t           r_state;
    op_t              r_op;
    logic [N_REQ-1:0] r_pend;
    logic             r_ovr;
    logic             w_xfer;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_rem;
    logic             w_found;
    op_t              w_idx;
    op_t              w_ptr;

    assign w_xfer     = op_valid_o & op_ready_i;
    assign w_clr      = w_xfer ? (N_REQ'(1) << r_op) : '0;
    assign w_rem      = r_pend & ~w_clr;
    assign op_valid_o = r_state == ISSUE;
    assign op_o       = r_op;
    assign pend_o     = r_pend;
    assign ovr_o      = r_ovr;
    assign busy_o     = op_valid_o | (|r_pend);

`ifdef OP_ISSUE_RR_EN
    op_t r_ptr;

    // the next search starts just above the opcode being accepted
    assign w_ptr = w_xfer ? r_op + op_t'(1) : r_ptr;

    // round-robin pointer advances on every accepted opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= '0;
        else if (w_xfer) r_ptr <= r_op + op_t'(1);
    end
`else
    assign w_ptr = '0;
`endif

    rr_pick u_pick (
        .req_i   (w_rem),
        .ptr_i   (w_ptr),
        .found_o (w_found),
        .idx_o   (w_idx)
    );

    // pending set/clear with set winning, sticky overrun, and the IDLE/ISSUE sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_pend  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_pend <= w_rem | req_i;
            r_ovr  <= (|(req_i & w_rem)) | (r_ovr & ~ovr_clr_i);
            if (!op_valid_o || w_xfer) begin
                if (w_found) begin
                    r_op    <= w_idx;
                    r_state <= ISSUE;
                end else begin
                    r_state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_op_issue_encoder.sv
// tb_op_issue_encoder: directed scoreboard bench; stimulus queues expected opcodes, a monitor checks each transfer
module tb_op_issue_encoder;
    import op_issue_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] req_i;
    op_t              op_o;
    logic             op_valid_o;
    logic             op_ready_i;
    logic [N_REQ-1:0] pend_o;
    logic             busy_o;
    logic             ovr_o;
    logic             ovr_clr_i;

    int  n_chk  = 0;
    int  n_fail = 0;
    op_t exp_q[$];

    op_issue_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .op_o       (op_o),
        .op_valid_o (op_valid_o),
        .op_ready_i (op_ready_i),
        .pend_o     (pend_o),
        .busy_o     (busy_o),
        .ovr_o      (ovr_o),
        .ovr_clr_i  (ovr_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every transfer must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && op_valid_o && op_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_issue", int'(op_o), -1);
            else chk("issue_order", int'(op_o), int'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_n = 1'b0; req_i = '0; op_ready_i = 1'b0; ovr_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(op_valid_o), 0);
        chk("rst_op", int'(op_o), 0);
        chk("rst_pend", int'(pend_o), 0);
        chk("rst_ovr", int'(ovr_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        tick();
        // round-robin sweep 0,5,10,15
        op_ready_i = 1'b1;
        req_i = 16'h8421;
        exp_q.push_back(4'd0); exp_q.push_back(4'd5); exp_q.push_back(4'd10); exp_q.push_back(4'd15);
        tick();
        req_i = '0;
        repeat (5) tick();
        chk("sweep_done_valid", int'(op_valid_o), 0);
        chk("sweep_done_pend", int'(pend_o), 0);
        // wrap: 0 then 15
        req_i = 16'h8001;
        exp_q.push_back(4'd0); exp_q.push_back(4'd15);
        tick();
        req_i = '0;
        repeat (3) tick();
        chk("wrap_done_valid", int'(op_valid_o), 0);
        // single request latency
        req_i = 16'h0008;
        exp_q.push_back(4'd3);
        tick();
        req_i = '0;
        chk("single_pend", int'(pend_o), 16'h0008);
        chk("single_not_yet_valid", int'(op_valid_o), 0);
        tick();
        chk("single_valid", int'(op_valid_o), 1);
        chk("single_op", int'(op_o), 3);
        tick();
        chk("single_after_valid", int'(op_valid_o), 0);
        chk("single_after_pend", int'(pend_o), 0);
        chk("single_after_busy", int'(busy_o), 0);
        // back-pressure hold
        op_ready_i = 1'b0;
        req_i = 16'h0020;
        exp_q.push_back(4'd5);
        tick();
        req_i = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_op", int'(op_o), 5);
            chk("bp_valid", int'(op_valid_o), 1);
            tick();
        end
        op_ready_i = 1'b1;
        tick();
        chk("bp_done_valid", int'(op_valid_o), 0);
        // arbitration rule distinguishes the two builds (pointer sits at 6 here)
        req_i = 16'h0041;
`ifdef OP_ISSUE_RR_EN
        exp_q.push_back(4'd6); exp_q.push_back(4'd0);
`else
        exp_q.push_back(4'd0); exp_q.push_back(4'd6);
`endif
        tick();
        req_i = '0;
        repeat (3) tick();
        chk("prio_done_valid", int'(op_valid_o), 0);
        // overrun while stalled
        op_ready_i = 1'b0;
        req_i = 16'h0004;
        tick();
        req_i = '0;
        tick();
        chk("ovr_setup_valid", int'(op_valid_o), 1);
        chk("ovr_setup_op", int'(op_o), 2);
        req_i = 16'h0004;
        tick();
        req_i = '0;
        chk("ovr_set", int'(ovr_o), 1);
        tick();
        chk("ovr_hold", int'(ovr_o), 1);
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        chk("ovr_clr", int'(ovr_o), 0);
        req_i = 16'h0004; ovr_clr_i = 1'b1;
        tick();
        req_i = '0; ovr_clr_i = 1'b0;
        chk("ovr_set_wins", int'(ovr_o), 1);
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        chk("ovr_clr2", int'(ovr_o), 0);
        // request arriving in its own transfer cycle is kept and reissued
        op_ready_i = 1'b1;
        req_i = 16'h0004;
        exp_q.push_back(4'd2); exp_q.push_back(4'd2);
        tick();
        req_i = '0;
        chk("same_cycle_pend", int'(pend_o), 16'h0004);
        chk("same_cycle_ovr", int'(ovr_o), 0);
        chk("same_cycle_valid", int'(op_valid_o), 0);
        tick();
        chk("reissue_valid", int'(op_valid_o), 1);
        chk("reissue_op", int'(op_o), 2);
        tick();
        chk("reissue_done_pend", int'(pend_o), 0);
        // asynchronous reset mid-issue
        op_ready_i = 1'b0;
        req_i = 16'h00F0;
        tick();
        req_i = '0;
        tick();
        chk("ar_valid", int'(op_valid_o), 1);
        chk("ar_op", int'(op_o), 4);
        req_i = 16'h0010;
        tick();
        req_i = '0;
        chk("ar_ovr", int'(ovr_o), 1);
        chk("ar_pend", int'(pend_o), 16'h00F0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_now_valid", int'(op_valid_o), 0);
        chk("ar_now_pend", int'(pend_o), 0);
        chk("ar_now_op", int'(op_o), 0);
        chk("ar_now_ovr", int'(ovr_o), 0);
        tick();
        rst_n = 1'b1;
        op_ready_i = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", int'(op_valid_o), 0);
        chk("post_rst_busy", int'(busy_o), 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/op_issue_encoder.md
Name: op_issue_encoder

Overview:
Sequential counterpart to the ALU's 4-to-16 opcode decoder. It collects one-hot operation requests from 16 control sources and arbitrates among them. It encodes the winner into a 4-bit opcode and issues it to the ALU over a valid/ready handshake, holding the opcode stable until the ALU accepts it. It sits between the front-end control (button/register interface) and the ALU opcode input.

Parameters:
N_REQ, 16, number of request sources; one per opcode slot.
OP_W, 4, opcode width; must equal clog2(N_REQ).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req_i  input  N_REQ  request pulses; bit k requests opcode k; multiple bits may be set
op_o  output  OP_W  issued opcode (binary index of granted request)
op_valid_o  output  1  op_o is valid
op_ready_i  input  1  ALU accepts op_o this cycle
pend_o  output  N_REQ  pending-request register
busy_o  output  1  op_valid_o high or pend_o nonzero
ovr_o  output  1  sticky overrun flag
ovr_clr_i  input  1  clears ovr_o

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While low, all state and outputs are held at zero: pend=0, op_o=0, op_valid_o=0, ptr=0, ovr_o=0, state=IDLE.
- Reset mid-issue: op_valid_o drops immediately (asynchronously) and all pending requests are lost.
- Handshake: a transfer occurs on a rising edge where op_valid_o && op_ready_i. While op_valid_o is high and op_ready_i is low, op_o and op_valid_o hold stable.
- pend update, each edge: pend <= (pend & ~grant_clr) | req_i.
  - grant_clr is the one-hot bit of op_o during a transfer cycle; otherwise it is 0.
  - If a bit is set and cleared in the same cycle, set wins; the new request is kept.
- Overrun: ovr_o sets when req_i[k]=1 while pend[k]=1 and k is not being cleared this cycle.
  - ovr_clr_i clears ovr_o. If a set and a clear occur in the same cycle, set wins.
- States:
  - IDLE (op_valid_o=0): if pend!=0, pick a winner from pend, load op_o=index and op_valid_o=1, go to ISSUE.
  - ISSUE (op_valid_o=1): on a transfer, compute rem = pend & ~grant_clr.
    - If rem!=0, pick the next winner from rem, load it, and stay in ISSUE. This gives back-to-back issue at one opcode per cycle.
    - Otherwise clear op_valid_o and go to IDLE.
- Request visibility: req_i bits arriving in a transfer cycle are not considered until the next cycle.
- Latency: a req_i pulse at edge t is in pend after t. op_valid_o goes high after edge t+1, provided the block was idle.
- Pick rule: round-robin starting at ptr, searching upward with wrap from index 15 to index 0.
  - On each transfer, ptr <= (op_o+1) mod N_REQ.
  - ptr wraps from 15 to 0.
- Empty pick (no bits set) is never loaded.

Optional Feature:
OP_ISSUE_RR_EN
- Defined: round-robin pick as above; ptr register present.
- Undefined: fixed priority, lowest index wins (right-arbiter rule); ptr removed; otherwise identical.

Decomposition:
- Package op_issue_pkg holds:
  - N_REQ and OP_W constants.
  - typedef op_t (logic [OP_W-1:0]).
  - Named opcode constants OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND, OP_NOR, OP_XNOR, OP_SHL, OP_SHR, OP_RST.
  - State enum {IDLE, ISSUE}.
- One combinational sub-module, rr_pick. It takes the request vector and ptr and returns a found flag and the binary index, using rotate, lowest-set-bit select, encode, then un-rotate.

Test Plan:
- Single request: reset released, req_i=16'h0008 for 1 cycle, op_ready_i=1 -> op_valid_o high 2 cycles after the pulse, op_o=3 for 1 cycle, then pend_o=0 and busy_o=0.
- Back-pressure: req_i=16'h0020, op_ready_i=0 for 5 cycles -> op_o=5 and op_valid_o=1 stable for all 5 cycles; one transfer when op_ready_i rises.
- Round-robin: req_i=16'h8421 once, op_ready_i=1 -> issue order 0,5,10,15 on consecutive cycles. With OP_ISSUE_RR_EN undefined, re-requesting bit 0 each cycle starves bit 5.
- Wrap: after issuing 15, request 16'h8001 -> order 0 then 15 (RR); ptr wraps to 0 after 15.
- Overrun and same-cycle set: pend=0x0004 with op_ready_i=0, pulse req_i=0x0004 -> ovr_o=1 and holds until ovr_clr_i. In a transfer cycle of op 2, req_i=0x0004 -> pend[2] stays 1, ovr_o unchanged, op 2 reissued.
- Async reset mid-issue: op_valid_o=1 with pend=0x00F0, pull rst_n low between edges -> op_valid_o, pend_o, op_o, ovr_o all 0 immediately with no clock edge; no issue after release until a new req_i.
